reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameters: RS_WIDTH, 2, log2 entry count (4 entries); RoB_WIDTH, 3, RoB index width; NON_DEP, 1<<RoB_WIDTH, "no dependency" tag.
REQ-002 SHALL have ports: clk_in in 1 clock; rst_in in 1 asynchronous active-low reset; rdy_in in 1 run enable (low = pause).
REQ-003 SHALL have dispatcher-side ports: RS_newEntry_en in 1; RS_robEntry in RoB_WIDTH; RS_opcode in 7; RS_Vj, RS_Vk, RS_imm, RS_pc in 32 each; RS_Qj, RS_Qk in RoB_WIDTH+1; RS_isFull out 1.
REQ-004 SHALL have CDB ports: alu_cdb_en in 1, alu_cdb_robIndex in RoB_WIDTH, alu_cdb_value in 32; lsb_cdb_en in 1, lsb_cdb_robIndex in RoB_WIDTH, lsb_cdb_value in 32.
REQ-005 SHALL have ports: RoB_flush_signal in 1 (mispredict flush).
REQ-006 SHALL have ALU-side registered outputs: alu_en out 1; alu_robIndex out RoB_WIDTH; alu_opcode out 7; alu_Vj, alu_Vk, alu_imm, alu_pc out 32 each.

Function
REQ-007 SHALL hold 2^RS_WIDTH entries: valid, robIndex, opcode, Vj, Vk, Qj, Qk, imm, pc.
REQ-008 SHALL write RS_newEntry_en data into the lowest-index invalid entry at the clock edge; with no free entry the request SHALL be dropped.
REQ-009 SHALL, on insertion, replace Qj (Qk) equal to {0,valid CDB robIndex} with NON_DEP and Vj (Vk) with that CDB's value in the same edge; ALU CDB checked before LSB CDB.
REQ-010 SHALL, every edge, for each valid entry, replace Qj/Qk matching an enabled CDB index with NON_DEP and capture the value; both CDBs may match different operands of one entry in one edge.
REQ-011 An entry is ready when valid and Qj==NON_DEP and Qk==NON_DEP on registered state.
REQ-012 SHALL select the lowest-index ready entry each cycle, drive its fields to the ALU outputs with alu_en=1 on the next edge, and invalidate it on that same edge; alu_en=0 when none ready.
REQ-013 Issue latency: entry inserted fully ready at edge N SHALL produce alu_en=1 after edge N+1; at most one issue per cycle.
REQ-014 Same-edge insert and issue SHALL be allowed; an entry freed by issue SHALL not be reused on that edge.
REQ-015 RS_isFull SHALL be combinational, 1 when free entries <=1 (covers the one in-flight dispatcher-registered entry).
REQ-016 RoB_flush_signal=1 SHALL clear all valid bits and alu_en on the next edge, ignoring insertion and CDBs that cycle; flush takes priority over everything except reset.
REQ-017 rdy_in=0 (no flush) SHALL hold all entry state, drive alu_en=0, ignore insertion and CDBs.
REQ-018 CDB indices matching no entry SHALL have no effect; Q tags SHALL be compared at full RoB_WIDTH+1 width.

Reset
REQ-019 rst_in low SHALL immediately clear all valid bits, alu_en, alu_robIndex, alu_opcode, alu_Vj, alu_Vk, alu_imm, alu_pc to 0, regardless of clock.
REQ-020 After rst_in deasserts, RS_isFull SHALL read 0 and first insertion SHALL go to entry 0.
REQ-021 Reset asserted mid-operation SHALL discard all entries; no partial issue SHALL follow.

Configuration
REQ-022 Macro RS_CDB_BYPASS_EN defined: an entry whose last pending operand is broadcast on a CDB this cycle SHALL count as ready this cycle, with the CDB value forwarded into alu_Vj/alu_Vk (wakeup-to-alu_en 1 edge).
REQ-023 RS_CDB_BYPASS_EN undefined: readiness uses registered Q only (wakeup-to-alu_en 2 edges); all other behaviour identical.

Verification
REQ-024 Insert addi robEntry=2, Qj=NON_DEP, Vj=5, imm=7 at edge 1 -> alu_en=1 after edge 2 with alu_robIndex=2, alu_Vj=5, alu_imm=7; entry freed.
REQ-025 Insert add Qj=3, Qk=NON_DEP, Vk=1; ALU CDB idx 3 value 0x10 next cycle -> alu_Vj=0x10, alu_en after 1 edge (bypass) / 2 edges (no bypass).
REQ-026 Insert three blocked entries -> RS_isFull=1; ALU CDB frees one by issue -> RS_isFull=0 after issue edge.
REQ-027 Insert with Qj=4 while LSB CDB idx 4 value 0xABCD same cycle -> stored Vj=0xABCD, Qj=NON_DEP; issues next edge.
REQ-028 Two entries ready (slots 1 and 3) plus flush same cycle -> alu_en=0, all invalid, RS_isFull=0 after edge.
REQ-029 Pull rst_in low between clock edges with 4 valid entries -> all outputs 0 immediately, no alu_en after release.

Source files
------------

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - 2^RS_WIDTH-entry reservation station with dual-CDB wakeup and lowest-slot issue
// Define RS_CDB_BYPASS_EN to let a same-cycle CDB broadcast complete readiness and forward into the issue operands.
module reservation_station #(
  parameter int RS_WIDTH = 2,
  parameter int RoB_WIDTH = 3,
  parameter logic [RoB_WIDTH:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}}
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 RS_newEntry_en,
  input  logic [RoB_WIDTH-1:0] RS_robEntry,
  input  logic [6:0]           RS_opcode,
  input  logic [31:0]          RS_Vj,
  input  logic [31:0]          RS_Vk,
  input  logic [31:0]          RS_imm,
  input  logic [31:0]          RS_pc,
  input  logic [RoB_WIDTH:0]   RS_Qj,
  input  logic [RoB_WIDTH:0]   RS_Qk,
  output logic                 RS_isFull,
  input  logic                 alu_cdb_en,
  input  logic [RoB_WIDTH-1:0] alu_cdb_robIndex,
  input  logic [31:0]          alu_cdb_value,
  input  logic                 lsb_cdb_en,
  input  logic [RoB_WIDTH-1:0] lsb_cdb_robIndex,
  input  logic [31:0]          lsb_cdb_value,
  input  logic                 RoB_flush_signal,
  output logic                 alu_en,
  output logic [RoB_WIDTH-1:0] alu_robIndex,
  output logic [6:0]           alu_opcode,
  output logic [31:0]          alu_Vj,
  output logic [31:0]          alu_Vk,
  output logic [31:0]          alu_imm,
  output logic [31:0]          alu_pc
);
  localparam int RS_SIZE = 1 << RS_WIDTH;

  logic [RS_SIZE-1:0]   valid;
  logic [RoB_WIDTH-1:0] rob_q [RS_SIZE];
  logic [6:0]           op_q  [RS_SIZE];
  logic [31:0]          vj_q  [RS_SIZE];
  logic [31:0]          vk_q  [RS_SIZE];
  logic [31:0]          imm_q [RS_SIZE];
  logic [31:0]          pc_q  [RS_SIZE];
  logic [RoB_WIDTH:0]   qj_q  [RS_SIZE];
  logic [RoB_WIDTH:0]   qk_q  [RS_SIZE];

  logic [31:0]          vj_eff [RS_SIZE];
  logic [31:0]          vk_eff [RS_SIZE];
  logic [RS_SIZE-1:0]   ready;
  logic [RS_WIDTH-1:0]  issue_idx;
  logic [RS_WIDTH-1:0]  free_idx;
  logic                 issue_found;
  logic                 free_found;
  logic [RS_WIDTH:0]    free_cnt;

  // Tags are compared at full width, so NON_DEP (MSB set) never matches a CDB index.
  function automatic logic alu_hit(input logic [RoB_WIDTH:0] q);
    return alu_cdb_en && (q == {1'b0, alu_cdb_robIndex});
  endfunction

  function automatic logic lsb_hit(input logic [RoB_WIDTH:0] q);
    return lsb_cdb_en && (q == {1'b0, lsb_cdb_robIndex});
  endfunction

  always_comb begin
    ready       = '0;
    issue_found = 1'b0;
    issue_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    free_cnt    = '0;
    // Descending scan so the last assignment wins with the lowest index.
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      vj_eff[i] = vj_q[i];
      vk_eff[i] = vk_q[i];
`ifdef RS_CDB_BYPASS_EN
      if (qj_q[i] != NON_DEP) vj_eff[i] = alu_hit(qj_q[i]) ? alu_cdb_value : lsb_cdb_value;
      if (qk_q[i] != NON_DEP) vk_eff[i] = alu_hit(qk_q[i]) ? alu_cdb_value : lsb_cdb_value;
      ready[i] = valid[i]
               && (qj_q[i] == NON_DEP || alu_hit(qj_q[i]) || lsb_hit(qj_q[i]))
               && (qk_q[i] == NON_DEP || alu_hit(qk_q[i]) || lsb_hit(qk_q[i]));
`else
      ready[i] = valid[i] && (qj_q[i] == NON_DEP) && (qk_q[i] == NON_DEP);
`endif
      if (ready[i]) begin
        issue_found = 1'b1;
        issue_idx   = RS_WIDTH'(i);
      end
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = RS_WIDTH'(i);
        free_cnt   = free_cnt + (RS_WIDTH + 1)'(1);
      end
    end
  end

  // One spare slot is reserved for the entry the dispatcher already has in flight.
  assign RS_isFull = (free_cnt <= (RS_WIDTH + 1)'(1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid        <= '0;
      alu_en       <= 1'b0;
      alu_robIndex <= '0;
      alu_opcode   <= '0;
      alu_Vj       <= '0;
      alu_Vk       <= '0;
      alu_imm      <= '0;
      alu_pc       <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        rob_q[i] <= '0;
        op_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
        qj_q[i]  <= NON_DEP;
        qk_q[i]  <= NON_DEP;
      end
    end else if (RoB_flush_signal) begin
      valid  <= '0;
      alu_en <= 1'b0;
    end else if (!rdy_in) begin
      alu_en <= 1'b0;
    end else begin
      alu_en <= issue_found;
      if (issue_found) begin
        alu_robIndex     <= rob_q[issue_idx];
        alu_opcode       <= op_q[issue_idx];
        alu_Vj           <= vj_eff[issue_idx];
        alu_Vk           <= vk_eff[issue_idx];
        alu_imm          <= imm_q[issue_idx];
        alu_pc           <= pc_q[issue_idx];
        valid[issue_idx] <= 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (valid[i]) begin
          if (alu_hit(qj_q[i])) begin
            qj_q[i] <= NON_DEP;
            vj_q[i] <= alu_cdb_value;
          end else if (lsb_hit(qj_q[i])) begin
            qj_q[i] <= NON_DEP;
            vj_q[i] <= lsb_cdb_value;
          end
          if (alu_hit(qk_q[i])) begin
            qk_q[i] <= NON_DEP;
            vk_q[i] <= alu_cdb_value;
          end else if (lsb_hit(qk_q[i])) begin
            qk_q[i] <= NON_DEP;
            vk_q[i] <= lsb_cdb_value;
          end
        end
      end
      // free_idx comes from registered valid, so a slot vacated by this edge's issue is never chosen.
      if (RS_newEntry_en && free_found) begin
        valid[free_idx] <= 1'b1;
        rob_q[free_idx] <= RS_robEntry;
        op_q[free_idx]  <= RS_opcode;
        imm_q[free_idx] <= RS_imm;
        pc_q[free_idx]  <= RS_pc;
        if (alu_hit(RS_Qj)) begin
          qj_q[free_idx] <= NON_DEP;
          vj_q[free_idx] <= alu_cdb_value;
        end else if (lsb_hit(RS_Qj)) begin
          qj_q[free_idx] <= NON_DEP;
          vj_q[free_idx] <= lsb_cdb_value;
        end else begin
          qj_q[free_idx] <= RS_Qj;
          vj_q[free_idx] <= RS_Vj;
        end
        if (alu_hit(RS_Qk)) begin
          qk_q[free_idx] <= NON_DEP;
          vk_q[free_idx] <= alu_cdb_value;
        end else if (lsb_hit(RS_Qk)) begin
          qk_q[free_idx] <= NON_DEP;
          vk_q[free_idx] <= lsb_cdb_value;
        end else begin
          qk_q[free_idx] <= RS_Qk;
          vk_q[free_idx] <= RS_Vk;
        end
      end
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed and random checks of reservation_station against an entry-list model
// Honours RS_CDB_BYPASS_EN the same way as the design build.
module tb_reservation_station;
  localparam logic [3:0] NON_DEP = 4'd8;
`ifdef RS_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        RS_newEntry_en = 1'b0;
  logic [2:0]  RS_robEntry = '0;
  logic [6:0]  RS_opcode = '0;
  logic [31:0] RS_Vj = '0, RS_Vk = '0, RS_imm = '0, RS_pc = '0;
  logic [3:0]  RS_Qj = NON_DEP, RS_Qk = NON_DEP;
  logic        RS_isFull;
  logic        alu_cdb_en = 1'b0;
  logic [2:0]  alu_cdb_robIndex = '0;
  logic [31:0] alu_cdb_value = '0;
  logic        lsb_cdb_en = 1'b0;
  logic [2:0]  lsb_cdb_robIndex = '0;
  logic [31:0] lsb_cdb_value = '0;
  logic        RoB_flush_signal = 1'b0;
  logic        alu_en;
  logic [2:0]  alu_robIndex;
  logic [6:0]  alu_opcode;
  logic [31:0] alu_Vj, alu_Vk, alu_imm, alu_pc;

  reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .RS_newEntry_en(RS_newEntry_en), .RS_robEntry(RS_robEntry), .RS_opcode(RS_opcode),
    .RS_Vj(RS_Vj), .RS_Vk(RS_Vk), .RS_imm(RS_imm), .RS_pc(RS_pc),
    .RS_Qj(RS_Qj), .RS_Qk(RS_Qk), .RS_isFull(RS_isFull),
    .alu_cdb_en(alu_cdb_en), .alu_cdb_robIndex(alu_cdb_robIndex), .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_en(lsb_cdb_en), .lsb_cdb_robIndex(lsb_cdb_robIndex), .lsb_cdb_value(lsb_cdb_value),
    .RoB_flush_signal(RoB_flush_signal),
    .alu_en(alu_en), .alu_robIndex(alu_robIndex), .alu_opcode(alu_opcode),
    .alu_Vj(alu_Vj), .alu_Vk(alu_Vk), .alu_imm(alu_imm), .alu_pc(alu_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          v;
    logic [2:0]  rob;
    logic [6:0]  op;
    logic [31:0] vj, vk, imm, pc;
    logic [3:0]  qj, qk;
  } ent_t;

  ent_t        m[4];
  logic        e_en;
  logic [2:0]  e_rob;
  logic [6:0]  e_op;
  logic [31:0] e_vj, e_vk, e_imm, e_pc;
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // An operand is available if untagged, or (when allowed) its producer is on a CDB now; ALU wins.
  function automatic void resolve(input logic [3:0] q, input logic [31:0] v, input bit use_cdb,
                                  output bit ok, output logic [31:0] val);
    ok = 1'b0;
    val = v;
    if (q == NON_DEP) ok = 1'b1;
    else if (use_cdb && alu_cdb_en && q == {1'b0, alu_cdb_robIndex}) begin ok = 1'b1; val = alu_cdb_value; end
    else if (use_cdb && lsb_cdb_en && q == {1'b0, lsb_cdb_robIndex}) begin ok = 1'b1; val = lsb_cdb_value; end
  endfunction

  function automatic int free_count();
    int n = 0;
    for (int i = 0; i < 4; i++) if (!m[i].v) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i].v = 1'b0;
    e_en = 0; e_rob = '0; e_op = '0; e_vj = '0; e_vk = '0; e_imm = '0; e_pc = '0;
  endtask

  task automatic model_step();
    ent_t nxt[4];
    bit okj, okk;
    logic [31:0] vj, vk;
    int sel, fr;
    nxt = m;
    if (RoB_flush_signal) begin
      for (int i = 0; i < 4; i++) nxt[i].v = 1'b0;
      e_en = 1'b0;
    end else if (!rdy_in) begin
      e_en = 1'b0;
    end else begin
      sel = -1;
      for (int i = 0; i < 4; i++) begin
        if (m[i].v && sel < 0) begin
          resolve(m[i].qj, m[i].vj, BYP, okj, vj);
          resolve(m[i].qk, m[i].vk, BYP, okk, vk);
          if (okj && okk) begin
            sel = i;
            e_rob = m[i].rob; e_op = m[i].op; e_vj = vj; e_vk = vk; e_imm = m[i].imm; e_pc = m[i].pc;
          end
        end
      end
      e_en = (sel >= 0);
      for (int i = 0; i < 4; i++) begin
        if (m[i].v) begin
          resolve(m[i].qj, m[i].vj, 1'b1, okj, vj);
          resolve(m[i].qk, m[i].vk, 1'b1, okk, vk);
          nxt[i].qj = okj ? NON_DEP : m[i].qj; nxt[i].vj = vj;
          nxt[i].qk = okk ? NON_DEP : m[i].qk; nxt[i].vk = vk;
        end
      end
      if (sel >= 0) nxt[sel].v = 1'b0;
      if (RS_newEntry_en) begin
        fr = -1;
        for (int i = 0; i < 4; i++) if (!m[i].v && fr < 0) fr = i;
        if (fr >= 0) begin
          resolve(RS_Qj, RS_Vj, 1'b1, okj, vj);
          resolve(RS_Qk, RS_Vk, 1'b1, okk, vk);
          nxt[fr].v = 1'b1; nxt[fr].rob = RS_robEntry; nxt[fr].op = RS_opcode;
          nxt[fr].imm = RS_imm; nxt[fr].pc = RS_pc;
          nxt[fr].qj = okj ? NON_DEP : RS_Qj; nxt[fr].vj = vj;
          nxt[fr].qk = okk ? NON_DEP : RS_Qk; nxt[fr].vk = vk;
        end
      end
    end
    m = nxt;
  endtask

  task automatic check_outputs();
    chk("alu_en", alu_en, e_en);
    if (e_en) begin
      chk("alu_robIndex", alu_robIndex, e_rob);
      chk("alu_opcode", alu_opcode, e_op);
      chk("alu_Vj", alu_Vj, e_vj);
      chk("alu_Vk", alu_Vk, e_vk);
      chk("alu_imm", alu_imm, e_imm);
      chk("alu_pc", alu_pc, e_pc);
    end
    chk("RS_isFull", RS_isFull, free_count() <= 1);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    RS_newEntry_en = 0; alu_cdb_en = 0; lsb_cdb_en = 0; RoB_flush_signal = 0; rdy_in = 1;
  endtask

  task automatic ins(input logic [2:0] rob, input logic [6:0] op, input logic [31:0] vj, input logic [31:0] vk,
                     input logic [3:0] qj, input logic [3:0] qk, input logic [31:0] imm, input logic [31:0] pc);
    RS_newEntry_en = 1; RS_robEntry = rob; RS_opcode = op; RS_Vj = vj; RS_Vk = vk;
    RS_Qj = qj; RS_Qk = qk; RS_imm = imm; RS_pc = pc;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_alu_en"}, alu_en, 0);
    chk({tag, "_alu_robIndex"}, alu_robIndex, 0);
    chk({tag, "_alu_opcode"}, alu_opcode, 0);
    chk({tag, "_alu_Vj"}, alu_Vj, 0);
    chk({tag, "_alu_Vk"}, alu_Vk, 0);
    chk({tag, "_alu_imm"}, alu_imm, 0);
    chk({tag, "_alu_pc"}, alu_pc, 0);
    chk({tag, "_RS_isFull"}, RS_isFull, 0);
  endtask

  function automatic logic [3:0] rand_q();
    logic [2:0] r = 3'($urandom_range(0, 7));
    return ($urandom_range(0, 2) == 0) ? NON_DEP : {1'b0, r};
  endfunction

  initial begin
    model_reset();
    #3;
    check_all_zero("reset");
    #9 rst_in = 1'b1;

    // Ready addi issues one edge after insertion.
    ins(3'd2, 7'h13, 32'd5, 32'd0, NON_DEP, NON_DEP, 32'd7, 32'h100);
    tick(); idle();
    chk("r024_no_early_issue", alu_en, 0);
    tick();
    chk("r024_en", alu_en, 1);
    chk("r024_rob", alu_robIndex, 2);
    chk("r024_vj", alu_Vj, 5);
    chk("r024_imm", alu_imm, 7);
    tick();
    chk("r024_freed", alu_en, 0);

    // Wakeup from the ALU CDB.
    ins(3'd1, 7'h33, 32'd0, 32'd1, 4'd3, NON_DEP, 32'd0, 32'h104);
    tick(); idle();
    alu_cdb_en = 1; alu_cdb_robIndex = 3'd3; alu_cdb_value = 32'h10;
    tick(); idle();
`ifdef RS_CDB_BYPASS_EN
    chk("r025_bypass_en", alu_en, 1);
    chk("r025_bypass_vj", alu_Vj, 32'h10);
`else
    chk("r025_wait_en", alu_en, 0);
    tick();
    chk("r025_en", alu_en, 1);
    chk("r025_vj", alu_Vj, 32'h10);
`endif
    tick();

    // Insert while the LSB CDB broadcasts the producer.
    ins(3'd5, 7'h33, 32'd0, 32'd2, 4'd4, NON_DEP, 32'd0, 32'h108);
    lsb_cdb_en = 1; lsb_cdb_robIndex = 3'd4; lsb_cdb_value = 32'hABCD;
    tick(); idle();
    chk("r027_not_yet", alu_en, 0);
    tick();
    chk("r027_en", alu_en, 1);
    chk("r027_vj", alu_Vj, 32'hABCD);
    tick();

    // Three blocked entries assert RS_isFull.
    ins(3'd0, 7'h33, 0, 0, 4'd5, NON_DEP, 0, 32'h200); tick();
    ins(3'd1, 7'h33, 0, 0, 4'd6, NON_DEP, 0, 32'h204); tick();
    ins(3'd2, 7'h33, 0, 0, 4'd7, NON_DEP, 0, 32'h208); tick(); idle();
    chk("r026_full", RS_isFull, 1);
    alu_cdb_en = 1; alu_cdb_robIndex = 3'd5; alu_cdb_value = 32'h55;
    tick(); idle();
`ifndef RS_CDB_BYPASS_EN
    chk("r026_still_full", RS_isFull, 1);
    tick();
`endif
    chk("r026_issue", alu_en, 1);
    chk("r026_not_full", RS_isFull, 0);
    RoB_flush_signal = 1; tick(); idle();

    // Two ready entries in slots 1 and 3 plus flush.
    ins(3'd0, 7'h33, 0, 0, 4'd1, NON_DEP, 0, 0); tick();
    ins(3'd1, 7'h33, 0, 0, 4'd2, NON_DEP, 0, 0); tick();
    ins(3'd2, 7'h33, 0, 0, 4'd3, NON_DEP, 0, 0); tick();
    ins(3'd3, 7'h33, 0, 0, 4'd4, NON_DEP, 0, 0); tick(); idle();
    alu_cdb_en = 1; alu_cdb_robIndex = 3'd2; alu_cdb_value = 32'h22;
    lsb_cdb_en = 1; lsb_cdb_robIndex = 3'd4; lsb_cdb_value = 32'h44;
    tick(); idle();
    RoB_flush_signal = 1;
    tick(); idle();
    chk("r028_en", alu_en, 0);
    chk("r028_not_full", RS_isFull, 0);
    tick();
    chk("r028_no_issue", alu_en, 0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      RoB_flush_signal = ($urandom_range(0, 39) == 0);
      RS_newEntry_en = $urandom_range(0, 1);
      RS_robEntry = 3'($urandom_range(0, 7));
      RS_opcode = 7'($urandom_range(0, 127));
      RS_Vj = $urandom; RS_Vk = $urandom; RS_imm = $urandom; RS_pc = $urandom;
      RS_Qj = rand_q(); RS_Qk = rand_q();
      alu_cdb_en = $urandom_range(0, 1);
      alu_cdb_robIndex = 3'($urandom_range(0, 7));
      alu_cdb_value = $urandom;
      lsb_cdb_en = $urandom_range(0, 1);
      lsb_cdb_robIndex = 3'($urandom_range(0, 7));
      lsb_cdb_value = $urandom;
      tick();
    end
    idle();
    RoB_flush_signal = 1; tick(); idle();

    // Asynchronous reset with four blocked entries.
    for (int i = 0; i < 4; i++) begin
      ins(3'(i), 7'h33, 32'(i), 0, 4'd6, NON_DEP, 32'(i), 32'(i));
      tick();
    end
    idle();
    chk("r029_full_before", RS_isFull, 1);
    #3 rst_in = 1'b0;
    model_reset();
    #1;
    check_all_zero("r029_async");
    #10;
    check_all_zero("r029_held");
    #3 rst_in = 1'b1;
    alu_cdb_en = 1; alu_cdb_robIndex = 3'd6; alu_cdb_value = 32'h66;
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r029_no_issue", alu_en, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
